// File: rtl/bpu_pkg.sv
// Shared types and defaults for the branch prediction unit.
// Word width, BTB geometry defaults and 2-bit counter encodings.
package bpu_pkg;

  localparam int WORD_W      = 32;
  localparam int BPU_ENTRIES = 64;
  localparam int BPU_TAG_W   = 10;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_t;

endpackage

// File: rtl/bpu_sat_ctr2.sv
// sat_ctr2: next value of a 2-bit saturating direction counter.
// Ports: ctr (current), taken, uncond in; nxt (next counter) out.
import bpu_pkg::*;

module sat_ctr2 (
  input  ctr_t ctr,
  input  logic taken,
  input  logic uncond,
  output ctr_t nxt
);

  always_comb begin
    nxt = ctr;
    if (uncond)
      nxt = CTR_ST;
    else if (taken)
      nxt = (ctr == CTR_ST) ? CTR_ST : ctr_t'(ctr + 2'd1);
    else
      nxt = (ctr == CTR_SNT) ? CTR_SNT : ctr_t'(ctr - 2'd1);
  end

endmodule

// File: rtl/bpu.sv
// bpu: direct-mapped BTB with 2-bit counters, combinational lookup of PC
// (Pre_Branch/Pre_PC), EX-side training, and branch/mispredict counters.
import bpu_pkg::*;

module bpu #(
  parameter int ENTRIES = BPU_ENTRIES,
  parameter int TAG_W   = BPU_TAG_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] PC,
  output logic              Pre_Branch,
  output logic [WORD_W-1:0] Pre_PC,
  input  logic              EX_Br_Valid,
  input  logic              EX_Stall,
  input  logic [WORD_W-1:0] EX_Br_PC,
  input  logic              EX_Br_Taken,
  input  logic [WORD_W-1:0] EX_Br_Target,
  input  logic              EX_Br_Uncond,
  input  logic              EX_Br_Mispred,
  output logic [31:0]       Br_Cnt,
  output logic [31:0]       Mispred_Cnt
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TOP   = IDX_W + 2 + TAG_W;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  word_t             target_q [ENTRIES];
  ctr_t              ctr_q    [ENTRIES];

  logic [IDX_W-1:0] l_idx;
  logic [TAG_W-1:0] l_tag;
  logic             l_hit;

  assign l_idx = PC[IDX_W+1:2];
  assign l_tag = PC[IDX_W+2 +: TAG_W];
  assign l_hit = valid_q[l_idx] && (tag_q[l_idx] == l_tag);

  // No bypass: same-index lookup sees the pre-update table.
  assign Pre_Branch = l_hit && ctr_q[l_idx][1];
  assign Pre_PC     = Pre_Branch ? target_q[l_idx] : '0;

  logic             upd;
  logic [IDX_W-1:0] u_idx;
  logic [TAG_W-1:0] u_tag;
  logic             u_hit;
  ctr_t             ctr_nxt;

  assign upd   = EX_Br_Valid && !EX_Stall;
  assign u_idx = EX_Br_PC[IDX_W+1:2];
  assign u_tag = EX_Br_PC[IDX_W+2 +: TAG_W];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  sat_ctr2 u_sat_ctr2 (
    .ctr    (ctr_q[u_idx]),
    .taken  (EX_Br_Taken),
    .uncond (EX_Br_Uncond),
    .nxt    (ctr_nxt)
  );

  logic unused_pc_bits;
  assign unused_pc_bits = ^{PC[1:0], PC[WORD_W-1:TOP],
                            EX_Br_PC[1:0], EX_Br_PC[WORD_W-1:TOP]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= CTR_WNT;
      end
    end else if (upd) begin
      if (u_hit) begin
        ctr_q[u_idx] <= ctr_nxt;
        if (EX_Br_Taken)
          target_q[u_idx] <= EX_Br_Target;
      end else if (EX_Br_Taken) begin
        valid_q[u_idx]  <= 1'b1;
        tag_q[u_idx]    <= u_tag;
        target_q[u_idx] <= EX_Br_Target;
        ctr_q[u_idx]    <= EX_Br_Uncond ? CTR_ST : CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Br_Cnt      <= '0;
      Mispred_Cnt <= '0;
    end else if (upd) begin
      Br_Cnt <= Br_Cnt + 32'd1;
      if (EX_Br_Mispred)
        Mispred_Cnt <= Mispred_Cnt + 32'd1;
    end
  end

endmodule
